// File: rtl/mem_responder.sv
// Shared word array serving an instruction-fetch port and a load/store port with a fixed latency.
// Define MEM_RESP_BOUND_CHK_EN to flag and suppress accesses beyond DEPTH*DATA_BYTE bytes.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 1,
    localparam int unsigned DATA_BYTE = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_addr_vld,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_rsp_data_vld,
    output logic [DATA_WIDTH-1:0] ifu_rsp_data,
    input  logic                  lsu_req_vld,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [DATA_WIDTH-1:0] lsu_req_data,
    input  logic [DATA_BYTE-1:0]  lsu_req_data_strobe,
    output logic                  lsu_rsp_vld,
    output logic [DATA_WIDTH-1:0] lsu_rsp_data,
    output logic                  mem_err
);

    localparam int unsigned OFF_W = $clog2(DATA_BYTE);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      ifu_idx, lsu_idx;
    logic                  ifu_oor, lsu_oor;
    logic [DATA_WIDTH-1:0] ifu_push, lsu_push;

    logic [LATENCY-1:0]                 ifu_vld_q, lsu_vld_q;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] ifu_dat_q, lsu_dat_q;

    // Offset and (in the aliasing build) upper address bits are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{ifu_req_addr, lsu_req_addr};

    assign ifu_idx = ifu_req_addr[OFF_W +: IDX_W];
    assign lsu_idx = lsu_req_addr[OFF_W +: IDX_W];

`ifdef MEM_RESP_BOUND_CHK_EN
    localparam longint unsigned SPAN = longint'(DEPTH) * longint'(DATA_BYTE);

    logic err_q, err_d;

    assign ifu_oor = 64'(ifu_req_addr) >= SPAN;
    assign lsu_oor = 64'(lsu_req_addr) >= SPAN;

    always_comb begin
        err_d = err_q;
        if ((ifu_req_addr_vld && ifu_oor) || (lsu_req_vld && lsu_oor)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    assign ifu_oor = 1'b0;
    assign lsu_oor = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Reads sample the array before this cycle's store lands, giving read-before-write.
    always_comb begin
        ifu_push = '0;
        lsu_push = '0;
        if (ifu_req_addr_vld) begin
            ifu_push = ifu_oor ? '1 : mem[ifu_idx];
        end
        if (lsu_req_vld) begin
            lsu_push = lsu_oor ? '1 : mem[lsu_idx];
        end
    end

    // Array is deliberately unreset; requests are ignored while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && lsu_req_vld && !lsu_oor) begin
            for (int k = 0; k < int'(DATA_BYTE); k++) begin
                if (lsu_req_data_strobe[k]) begin
                    mem[lsu_idx][8*k +: 8] <= lsu_req_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_vld_q <= '0;
            ifu_dat_q <= '0;
            lsu_vld_q <= '0;
            lsu_dat_q <= '0;
        end else begin
            ifu_vld_q[0] <= ifu_req_addr_vld;
            ifu_dat_q[0] <= ifu_push;
            lsu_vld_q[0] <= lsu_req_vld;
            lsu_dat_q[0] <= lsu_push;
            for (int i = 1; i < int'(LATENCY); i++) begin
                ifu_vld_q[i] <= ifu_vld_q[i-1];
                ifu_dat_q[i] <= ifu_dat_q[i-1];
                lsu_vld_q[i] <= lsu_vld_q[i-1];
                lsu_dat_q[i] <= lsu_dat_q[i-1];
            end
        end
    end

    assign ifu_rsp_data_vld = ifu_vld_q[LATENCY-1];
    assign ifu_rsp_data     = ifu_dat_q[LATENCY-1];
    assign lsu_rsp_vld      = lsu_vld_q[LATENCY-1];
    assign lsu_rsp_data     = lsu_dat_q[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: random and directed traffic on both ports, checked
// against a word-array reference model; honours MEM_RESP_BOUND_CHK_EN when defined.
module tb_mem_responder;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DB    = DW / 8;
`ifdef MEM_RESP_BOUND_CHK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_req_addr_vld;
    logic [AW-1:0] ifu_req_addr;
    logic          ifu_rsp_data_vld;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_vld;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_data;
    logic [DB-1:0] lsu_req_data_strobe;
    logic          lsu_rsp_vld;
    logic [DW-1:0] lsu_rsp_data;
    logic          mem_err;

    mem_responder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ifu_req_addr_vld   (ifu_req_addr_vld),
        .ifu_req_addr       (ifu_req_addr),
        .ifu_rsp_data_vld   (ifu_rsp_data_vld),
        .ifu_rsp_data       (ifu_rsp_data),
        .lsu_req_vld        (lsu_req_vld),
        .lsu_req_addr       (lsu_req_addr),
        .lsu_req_data       (lsu_req_data),
        .lsu_req_data_strobe(lsu_req_data_strobe),
        .lsu_rsp_vld        (lsu_rsp_vld),
        .lsu_rsp_data       (lsu_rsp_data),
        .mem_err            (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
        bit          dc;
    } exp_t;

    exp_t        ifu_q[$];
    exp_t        lsu_q[$];
    logic [31:0] ref_mem [DEPTH];
    bit          ref_known [DEPTH];
    bit          err_set = 1'b0;
    int unsigned err_due = 0;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned idx_of(logic [31:0] a);
        return (a / DB) % DEPTH;
    endfunction

    function automatic bit oor(logic [31:0] a);
        return BOUND_EN && (a >= 32'(DEPTH * DB));
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each port every cycle against the head of its expectation queue.
    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        ev = ifu_q.size() > 0 && ifu_q[0].due == cyc;
        check("ifu_vld", {31'd0, ifu_rsp_data_vld}, {31'd0, ev});
        if (ev) begin
            e = ifu_q.pop_front();
            if (ifu_rsp_data_vld && !e.dc) check("ifu_data", ifu_rsp_data, e.data);
        end else begin
            check("ifu_idle_data", ifu_rsp_data, 32'd0);
        end
        ev = lsu_q.size() > 0 && lsu_q[0].due == cyc;
        check("lsu_vld", {31'd0, lsu_rsp_vld}, {31'd0, ev});
        if (ev) begin
            e = lsu_q.pop_front();
            if (lsu_rsp_vld && !e.dc) check("lsu_data", lsu_rsp_data, e.data);
        end else begin
            check("lsu_idle_data", lsu_rsp_data, 32'd0);
        end
        check("mem_err", {31'd0, mem_err}, {31'd0, err_set && cyc >= err_due});
    end

    task automatic set_idle();
        ifu_req_addr_vld    = 1'b0;
        ifu_req_addr        = '0;
        lsu_req_vld         = 1'b0;
        lsu_req_addr        = '0;
        lsu_req_data        = '0;
        lsu_req_data_strobe = '0;
    endtask

    // One request cycle on both ports, with the model updated read-before-write.
    task automatic do_cycle(bit iv, logic [31:0] ia, bit lv, logic [31:0] la,
                            logic [31:0] ld, logic [3:0] ls);
        exp_t        e;
        int unsigned ii, li;
        @(posedge clk);
        #1;
        ifu_req_addr_vld    = iv;
        ifu_req_addr        = ia;
        lsu_req_vld         = lv;
        lsu_req_addr        = la;
        lsu_req_data        = ld;
        lsu_req_data_strobe = ls;
        ii = idx_of(ia);
        li = idx_of(la);
        if (iv) begin
            e.due  = cyc + LAT;
            e.dc   = !oor(ia) && !ref_known[ii];
            e.data = oor(ia) ? 32'hFFFF_FFFF : ref_mem[ii];
            ifu_q.push_back(e);
        end
        if (lv) begin
            e.due  = cyc + LAT;
            e.dc   = !oor(la) && !ref_known[li];
            e.data = oor(la) ? 32'hFFFF_FFFF : ref_mem[li];
            lsu_q.push_back(e);
            if (!oor(la)) begin
                for (int k = 0; k < 4; k++) begin
                    if (ls[k]) ref_mem[li][8*k +: 8] = ld[8*k +: 8];
                end
                if (ls == 4'hF) ref_known[li] = 1'b1;
            end
        end
        if (((iv && oor(ia)) || (lv && oor(la))) && !err_set) begin
            err_set = 1'b1;
            err_due = cyc + 1;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'h0);
    endtask

    // Reset mid-flight; a store driven while reset is held must not land.
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        set_idle();
        #2;
        rst_n = 1'b0;
        ifu_q.delete();
        lsu_q.delete();
        err_set = 1'b0;
        lsu_req_vld         = 1'b1;
        lsu_req_addr        = 32'h80;
        lsu_req_data        = 32'hBAD0_BAD0;
        lsu_req_data_strobe = 4'hF;
        repeat (2) @(posedge clk);
        #3;
        set_idle();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) < 7) return 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
        return 32'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ls;
        set_idle();
        #23;
        rst_n = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) begin
            do_cycle(1'b0, 32'd0, 1'b1, 32'(i * 4), 32'($urandom), 4'hF);
        end

        do_cycle(1'b0, 32'd0, 1'b1, 32'h10, 32'h0000_0013, 4'hF);
        do_cycle(1'b1, 32'h10, 1'b0, 32'd0, 32'd0, 4'h0);
        idle(2);
        do_cycle(1'b0, 32'd0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
        do_cycle(1'b0, 32'd0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        do_cycle(1'b0, 32'd0, 1'b1, 32'h22, 32'h0, 4'h0);
        do_cycle(1'b0, 32'd0, 1'b1, 32'h40, 32'h0, 4'hF);
        do_cycle(1'b1, 32'h40, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
        do_cycle(1'b1, 32'h40, 1'b0, 32'd0, 32'd0, 4'h0);
        do_cycle(1'b1, 32'h0, 1'b0, 32'd0, 32'd0, 4'h0);
        do_cycle(1'b1, 32'h4, 1'b0, 32'd0, 32'd0, 4'h0);
        do_cycle(1'b1, 32'h8, 1'b0, 32'd0, 32'd0, 4'h0);
        idle(4);

        do_cycle(1'b0, 32'd0, 1'b1, 32'h80, 32'h5A5A_1234, 4'hF);
        do_cycle(1'b1, 32'h0, 1'b1, 32'h84, 32'd0, 4'h0);
        pulse_reset();
        idle(LAT + 2);
        do_cycle(1'b1, 32'h80, 1'b1, 32'h80, 32'd0, 4'h0);
        idle(LAT + 1);

        do_cycle(1'b0, 32'd0, 1'b1, 32'h1000, 32'd0, 4'h0);
        do_cycle(1'b0, 32'd0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
        do_cycle(1'b0, 32'd0, 1'b1, 32'h0, 32'd0, 4'h0);
        idle(LAT + 1);

        for (int i = 0; i < 800; i++) begin
            if (i == 400) pulse_reset();
            ls = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            do_cycle(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
                     rand_addr(), 32'($urandom), ls);
        end
        idle(LAT + 2);

        total++;
        if (ifu_q.size() != 0 || lsu_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", ifu_q.size(), lsu_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
